// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between the IF fetch port and the MEM data port.
// Latency: request seen in IDLE -> gnt next cycle -> valid MEM_LAT+1 cycles after gnt.
// Backpressure: requester holds req until valid; stall_if/stall_mem freeze the pipeline meanwhile.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request (held until if_valid)
//   if_gnt/if_valid/if_rdata      fetch issue pulse, data-valid pulse, fetched word
//   dm_req/dm_we/dm_addr/dm_wdata data request (held until dm_valid)
//   dm_gnt/dm_valid/dm_rdata      data issue pulse, completion pulse, read word
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory interface
//   stall_if/stall_mem            per-port stall (req & ~valid)
//   contend_cnt/if_stall_cnt      perf counters, only present with ARB_PERF_CNT_EN defined
//
// Optional feature macro: ARB_PERF_CNT_EN

module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       contend_cnt,
  output logic [31:0]       if_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);

  state_t     state;
  logic       win_dm;      // winner of the current access: 1 = data port
  logic       win_we;      // current access is a write (no read data capture)
  logic [3:0] starve_cnt;
  logic [2:0] lat_cnt;

  // IF is forced through only when it has lost STARVE_MAX contended rounds in a row.
  logic force_if;
  logic grant_dm;
  assign force_if = if_req & dm_req & (starve_cnt == STARVE_LIM);
  assign grant_dm = dm_req & ~force_if;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      win_dm     <= 1'b0;
      win_we     <= 1'b0;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      if_gnt     <= 1'b0;
      dm_gnt     <= 1'b0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      // Pulses and the memory strobe default low; only set for their single cycle.
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;

      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            state  <= ISSUE;
            win_dm <= grant_dm;
            mem_en <= 1'b1;
            if (grant_dm) begin
              win_we    <= dm_we;
              dm_gnt    <= 1'b1;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              // Only a contended win by DM counts against IF.
              if (if_req) begin
                starve_cnt <= (starve_cnt == STARVE_LIM) ? STARVE_LIM : starve_cnt + 4'd1;
              end
            end else begin
              win_we     <= 1'b0;
              if_gnt     <= 1'b1;
              mem_addr   <= if_addr;
              starve_cnt <= '0;
            end
          end
        end

        ISSUE: begin
          lat_cnt <= LAT_LOAD;
          state   <= WAIT;
        end

        WAIT: begin
          if (lat_cnt == 3'd0) begin
            state <= RESP;
            if (win_dm) begin
              dm_valid <= 1'b1;
              // A write acknowledges without disturbing the last read data.
              if (!win_we) begin
                dm_rdata <= mem_rdata;
              end
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      contend_cnt  <= '0;
      if_stall_cnt <= '0;
    end else begin
      if ((state == IDLE) && if_req && dm_req) begin
        contend_cnt <= contend_cnt + 32'd1;
      end
      if (stall_if) begin
        if_stall_cnt <= if_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-cycle vector table on a MEM_LAT=1 instance,
// plus sequences for starvation, reset mid-access and a MEM_LAT=3 instance.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        dm_req;
  logic        dm_we;
  logic [7:0]  dm_addr;
  logic [31:0] dm_wdata;

  logic        if_gnt1, if_valid1, dm_gnt1, dm_valid1, mem_en1, mem_we1, stall_if1, stall_mem1;
  logic [7:0]  mem_addr1;
  logic [31:0] if_rdata1, dm_rdata1, mem_wdata1, mem_rdata1;
  logic        if_gnt3, if_valid3, dm_gnt3, dm_valid3, mem_en3, mem_we3, stall_if3, stall_mem3;
  logic [7:0]  mem_addr3;
  logic [31:0] if_rdata3, dm_rdata3, mem_wdata3, mem_rdata3;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] cc1, isc1, cc3, isc3;
`endif

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_valid(if_valid1), .if_rdata(if_rdata1),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt1), .dm_valid(dm_valid1), .dm_rdata(dm_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall_if(stall_if1), .stall_mem(stall_mem1)
`ifdef ARB_PERF_CNT_EN
    , .contend_cnt(cc1), .if_stall_cnt(isc1)
`endif
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_valid(if_valid3), .if_rdata(if_rdata3),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt3), .dm_valid(dm_valid3), .dm_rdata(dm_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .stall_if(stall_if3), .stall_mem(stall_mem3)
`ifdef ARB_PERF_CNT_EN
    , .contend_cnt(cc3), .if_stall_cnt(isc3)
`endif
  );

  localparam logic [31:0] WA = 32'h8C22_0000;
  localparam logic [31:0] WB = 32'h1111_1111;
  localparam logic [31:0] WC = 32'h2222_2222;
  localparam logic [31:0] WD = 32'h3333_0020;
  localparam logic [31:0] WW = 32'hDEAD_BEEF;

  function automatic logic [31:0] init_word(input int a);
    case (a)
      'h04:    return WA;
      'h08:    return WB;
      'h0C:    return WC;
      'h20:    return WD;
      default: return 32'hA000_0000 | 32'(a);
    endcase
  endfunction

  // Synchronous memories: read data registered one cycle after mem_en, held until the next access.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem1[i] <= init_word(i);
    end else if (mem_en1) begin
      if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
      mem_rdata1 <= mem1[mem_addr1];
    end
  end
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem3[i] <= init_word(i);
    end else if (mem_en3) begin
      if (mem_we3) mem3[mem_addr3] <= mem_wdata3;
      mem_rdata3 <= mem3[mem_addr3];
    end
  end

  typedef struct packed {
    logic        if_req;
    logic [7:0]  if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wdata;
  } in_t;

  // flags = {if_gnt, if_valid, dm_gnt, dm_valid, mem_en, mem_we}; stalls = {stall_if, stall_mem}
  typedef struct packed {
    logic [5:0]  flags;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  stalls;
    logic [31:0] if_rdata;
    logic [31:0] dm_rdata;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  localparam logic [5:0] F0   = 6'b000000;
  localparam logic [5:0] FIG  = 6'b100010;
  localparam logic [5:0] FIV  = 6'b010000;
  localparam logic [5:0] FDGW = 6'b001011;
  localparam logic [5:0] FDGR = 6'b001010;
  localparam logic [5:0] FDV  = 6'b000100;

  int n_pass  = 0;
  int n_total = 0;
  vec_t tbl[$];

  function automatic vec_t mk(input logic ir, input logic [7:0] ia, input logic dr, input logic dw,
                              input logic [7:0] da, input logic [31:0] dd, input logic [5:0] f,
                              input logic [7:0] ma, input logic [31:0] mw, input logic [1:0] st,
                              input logic [31:0] ird, input logic [31:0] drd);
    vec_t v;
    v.i = '{if_req: ir, if_addr: ia, dm_req: dr, dm_we: dw, dm_addr: da, dm_wdata: dd};
    v.o = '{flags: f, mem_addr: ma, mem_wdata: mw, stalls: st, if_rdata: ird, dm_rdata: drd};
    return v;
  endfunction

  function automatic out_t cap1();
    out_t o;
    o.flags     = {if_gnt1, if_valid1, dm_gnt1, dm_valid1, mem_en1, mem_we1};
    o.mem_addr  = mem_addr1;
    o.mem_wdata = mem_wdata1;
    o.stalls    = {stall_if1, stall_mem1};
    o.if_rdata  = if_rdata1;
    o.dm_rdata  = dm_rdata1;
    return o;
  endfunction

  function automatic out_t cap3();
    out_t o;
    o.flags     = {if_gnt3, if_valid3, dm_gnt3, dm_valid3, mem_en3, mem_we3};
    o.mem_addr  = mem_addr3;
    o.mem_wdata = mem_wdata3;
    o.stalls    = {stall_if3, stall_mem3};
    o.if_rdata  = if_rdata3;
    o.dm_rdata  = dm_rdata3;
    return o;
  endfunction

  task automatic apply(input in_t v);
    if_req   = v.if_req;
    if_addr  = v.if_addr;
    dm_req   = v.dm_req;
    dm_we    = v.dm_we;
    dm_addr  = v.dm_addr;
    dm_wdata = v.dm_wdata;
  endtask

  task automatic chk(input string nm, input out_t act, input out_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] gseq [10];
    int         ng;
    out_t       e;

    // Cycle-by-cycle vectors, MEM_LAT=1.
    // Fetch from 0x04.
    tbl.push_back(mk(1, 8'h04, 0, 0, 8'h00, 32'h0, F0,   8'h00, 32'h0, 2'b10, 32'h0, 32'h0));
    tbl.push_back(mk(1, 8'h04, 0, 0, 8'h00, 32'h0, FIG,  8'h04, 32'h0, 2'b10, 32'h0, 32'h0));
    tbl.push_back(mk(1, 8'h04, 0, 0, 8'h00, 32'h0, F0,   8'h00, 32'h0, 2'b10, 32'h0, 32'h0));
    tbl.push_back(mk(1, 8'h04, 0, 0, 8'h00, 32'h0, FIV,  8'h00, 32'h0, 2'b00, WA,    32'h0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 32'h0, F0,   8'h00, 32'h0, 2'b00, WA,    32'h0));
    // Simultaneous: DM write 0x10 wins, then IF fetch 0x08.
    tbl.push_back(mk(1, 8'h08, 1, 1, 8'h10, WW,    F0,   8'h00, 32'h0, 2'b11, WA,    32'h0));
    tbl.push_back(mk(1, 8'h08, 1, 1, 8'h10, WW,    FDGW, 8'h10, WW,    2'b11, WA,    32'h0));
    tbl.push_back(mk(1, 8'h08, 1, 1, 8'h10, WW,    F0,   8'h00, 32'h0, 2'b11, WA,    32'h0));
    tbl.push_back(mk(1, 8'h08, 1, 1, 8'h10, WW,    FDV,  8'h00, 32'h0, 2'b10, WA,    32'h0));
    tbl.push_back(mk(1, 8'h08, 0, 0, 8'h00, 32'h0, F0,   8'h00, 32'h0, 2'b10, WA,    32'h0));
    tbl.push_back(mk(1, 8'h08, 0, 0, 8'h00, 32'h0, FIG,  8'h08, 32'h0, 2'b10, WA,    32'h0));
    tbl.push_back(mk(1, 8'h08, 0, 0, 8'h00, 32'h0, F0,   8'h00, 32'h0, 2'b10, WA,    32'h0));
    tbl.push_back(mk(1, 8'h08, 0, 0, 8'h00, 32'h0, FIV,  8'h00, 32'h0, 2'b00, WB,    32'h0));
    // Read back 0x10.
    tbl.push_back(mk(0, 8'h00, 1, 0, 8'h10, 32'h0, F0,   8'h00, 32'h0, 2'b01, WB,    32'h0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 8'h10, 32'h0, FDGR, 8'h10, 32'h0, 2'b01, WB,    32'h0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 8'h10, 32'h0, F0,   8'h00, 32'h0, 2'b01, WB,    32'h0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 8'h10, 32'h0, FDV,  8'h00, 32'h0, 2'b00, WB,    WW));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 32'h0, F0,   8'h00, 32'h0, 2'b00, WB,    WW));
    // DM request raised during IF service then withdrawn before any grant.
    tbl.push_back(mk(1, 8'h0C, 0, 0, 8'h00, 32'h0, F0,   8'h00, 32'h0, 2'b10, WB,    WW));
    tbl.push_back(mk(1, 8'h0C, 1, 0, 8'h20, 32'h0, FIG,  8'h0C, 32'h0, 2'b11, WB,    WW));
    tbl.push_back(mk(1, 8'h0C, 0, 0, 8'h00, 32'h0, F0,   8'h00, 32'h0, 2'b10, WB,    WW));
    tbl.push_back(mk(1, 8'h0C, 0, 0, 8'h00, 32'h0, FIV,  8'h00, 32'h0, 2'b00, WC,    WW));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 32'h0, F0,   8'h00, 32'h0, 2'b00, WC,    WW));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 32'h0, F0,   8'h00, 32'h0, 2'b00, WC,    WW));

    // Reset.
    rst = 1'b1;
    apply('0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_dut1", cap1(), '0);
    chk("reset_dut3", cap3(), '0);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      apply(tbl[k].i);
      #1;
      chk($sformatf("row%0d", k), cap1(), tbl[k].o);
    end

    // Starvation guard: both ports requesting continuously.
    for (int g = 0; g < 10; g++) gseq[g] = 2'd0;
    ng = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h30;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h40; dm_wdata = 32'h0;
    for (int c = 0; c < 48; c++) begin
      #1;
      if (ng < 10 && (if_gnt1 || dm_gnt1)) begin
        gseq[ng] = {dm_gnt1, if_gnt1};
        ng++;
      end
      @(negedge clk);
    end
    apply('0);
    for (int g = 0; g < 10; g++) begin
      chk_val($sformatf("starve_gnt%0d", g), 32'(gseq[g]), (g == 4 || g == 9) ? 32'd1 : 32'd2);
    end
    repeat (8) @(negedge clk);

    // Reset while an IF access sits in WAIT.
    if_req = 1'b1; if_addr = 8'h04;
    @(negedge clk);
    #1;
    chk_val("rst_seq_gnt", 32'(if_gnt1), 32'd1);
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_seq_clear", cap1(), '0);
    @(negedge clk);
    #1;
    chk("rst_seq_novalid", cap1(), '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 8'h04;
      #1;
      e = '0;
      e.flags    = (k == 1) ? FIG : (k == 3) ? FIV : F0;
      e.mem_addr = (k == 1) ? 8'h04 : 8'h00;
      e.stalls   = (k < 3) ? 2'b10 : 2'b00;
      e.if_rdata = (k == 3) ? WA : 32'h0;
      chk($sformatf("rst_seq_fresh%0d", k), cap1(), e);
    end
    @(negedge clk);
    apply('0);

    // MEM_LAT=3 data read at 0x20.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      dm_req = (c <= 5); dm_we = 1'b0; dm_addr = 8'h20; dm_wdata = 32'h0;
      #1;
      chk_val($sformatf("lat3_c%0d", c), {28'h0, dm_gnt3, mem_en3, dm_valid3, stall_mem3},
              {28'h0, (c == 1), (c == 1), (c == 5), (c <= 4)});
      if (c == 1) chk_val("lat3_addr", 32'(mem_addr3), 32'h20);
      if (c == 5) chk_val("lat3_rdata", dm_rdata3, WD);
    end
    apply('0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
